better_neighbor_scan: RTL and testbench

Upstream stage of rngAddress. On start, it latches the current solution cost and streams every neighbour cost from a synchronous-read cost memory. It records the indices of strictly better neighbours in an internal list. It then reports betterNeighborCount and a done flag, which rngAddress uses as its count input and start trigger. It also serves the index list back, so the random slot chosen by rngAddress resolves to a real neighbour id.

---
 rtl/better_neighbor_scan_pkg.sv | 18 +
 rtl/better_list_buf.sv | 60 ++++++
 rtl/better_neighbor_scan.sv | 152 +++++++++++++++
 tb/tb_better_neighbor_scan.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/better_neighbor_scan_pkg.sv
// Shared definitions for the better-neighbour scan and its consumer (rngAddress).
package better_neighbor_scan_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Default neighbour cost width
    localparam int COST_W = 16;

    // Width of counts, neighbour addresses and list slots; rngAddress uses the same width
    localparam int CNT_AW = 16;

endpackage

// File: rtl/better_list_buf.sv
// Better-neighbour index list: a MAX_BETTER-deep register file written in order,
// with a saturating write pointer, sticky overflow flag and a bounded lookup port.
module better_list_buf #(
    parameter int MAX_BETTER = 16
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        i_clr,
    input  logic        i_wr,
    input  logic [15:0] i_idx,
    input  logic [15:0] i_sel,
    output logic [15:0] o_count,
    output logic        o_overflow,
    output logic [15:0] o_sel_neighbor
);
    import better_neighbor_scan_pkg::*;

    localparam int CNT_W = $clog2(MAX_BETTER) + 1;
    localparam int IDX_W = (MAX_BETTER > 1) ? $clog2(MAX_BETTER) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BETTER);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [15:0]       r_list [MAX_BETTER];
    logic              w_has_room;
    logic [CNT_AW-1:0] w_cnt_ext;

    assign w_has_room = (r_cnt < MAX_CNT);
    assign w_cnt_ext  = {{(CNT_AW-CNT_W){1'b0}}, r_cnt};

    // Write pointer and sticky overflow; a full list drops further indices
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_wr) begin
            if (w_has_room) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    // List storage; contents are don't-care after reset so they carry no reset
    always_ff @(posedge clock) begin
        if (nreset && !i_clr && i_wr && w_has_room) begin
            r_list[r_cnt[IDX_W-1:0]] <= i_idx;
        end
    end

    assign o_count        = w_cnt_ext;
    assign o_overflow     = r_ovf;
    // Slots at or beyond the count read as zero so stale entries never leak out
    assign o_sel_neighbor = (i_sel < w_cnt_ext) ? r_list[i_sel[IDX_W-1:0]] : 16'd0;

endmodule

// File: rtl/better_neighbor_scan.sv
// Scans all neighbour costs from a synchronous-read memory and collects the
// indices of neighbours strictly cheaper than the cost latched at scan start.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start_scan; previous count still visible
//   ST_SCAN  | issuing neighbour addresses 0..NUM_NEIGHBORS-1
//   ST_DRAIN | reads finished, waiting for the compare pipeline to empty
//   ST_DONE  | results valid, done_scan high until start_scan drops
module better_neighbor_scan #(
    parameter int NUM_NEIGHBORS = 8,
    parameter int MAX_BETTER    = 16,
    parameter int COST_W        = better_neighbor_scan_pkg::COST_W
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              start_scan,
    input  logic [COST_W-1:0] current_cost,
    output logic [15:0]       nb_addr,
    output logic              nb_rd_en,
    input  logic [COST_W-1:0] nb_cost,
    output logic [15:0]       betterNeighborCount,
    output logic              overflow,
    output logic              done_scan,
    input  logic [15:0]       sel_index,
    output logic [15:0]       sel_neighbor
);
    import better_neighbor_scan_pkg::*;

    localparam logic [CNT_AW-1:0] LAST_ADDR = CNT_AW'(NUM_NEIGHBORS - 1);

    scan_state_t       r_state, w_state_nxt;
    logic [CNT_AW-1:0] r_addr, w_addr_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic              r_done, w_done_nxt;
    logic              w_accept;

    logic [COST_W-1:0] r_cost_lat;
    logic              r_rd_d;
    logic [CNT_AW-1:0] r_addr_d;
    logic              r_cmp_vld;
    logic [CNT_AW-1:0] r_cmp_addr;
    logic [COST_W-1:0] r_cost_q;
    logic              w_better;

    // State register and registered memory-interface/done outputs
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rd_en <= w_rd_en_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rd_en_nxt = r_rd_en;
        w_done_nxt  = r_done;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_scan) begin
                    w_accept    = 1'b1;
                    w_addr_nxt  = '0;
                    w_rd_en_nxt = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_addr < LAST_ADDR) begin
                    w_addr_nxt  = r_addr + CNT_AW'(1);
                    w_rd_en_nxt = 1'b1;
                end else begin
                    w_rd_en_nxt = 1'b0;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last read datum has moved into the compare stage; it is written this edge
                if (!r_rd_d) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_scan) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reference cost captured once per scan so later current_cost changes are ignored
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_cost_lat <= '0;
        end else if (w_accept) begin
            r_cost_lat <= current_cost;
        end
    end

    // Compare pipeline: align the returned datum with its address, then register it
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_rd_d     <= 1'b0;
            r_addr_d   <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
            r_cost_q   <= '0;
        end else begin
            r_rd_d     <= r_rd_en;
            r_addr_d   <= r_addr;
            r_cmp_vld  <= r_rd_d;
            r_cmp_addr <= r_addr_d;
            r_cost_q   <= nb_cost;
        end
    end

    assign w_better = r_cmp_vld && (r_cost_q < r_cost_lat);

    better_list_buf #(
        .MAX_BETTER (MAX_BETTER)
    ) u_list (
        .clock          (clock),
        .nreset         (nreset),
        .i_clr          (w_accept),
        .i_wr           (w_better),
        .i_idx          (r_cmp_addr),
        .i_sel          (sel_index),
        .o_count        (betterNeighborCount),
        .o_overflow     (overflow),
        .o_sel_neighbor (sel_neighbor)
    );

    assign nb_addr   = r_addr;
    assign nb_rd_en  = r_rd_en;
    assign done_scan = r_done;

endmodule

// File: tb/tb_better_neighbor_scan.sv
// Directed bench for better_neighbor_scan: a default instance and a MAX_BETTER=4
// instance share stimulus and a one-cycle-latency cost memory model.
module tb_better_neighbor_scan;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start_scan;
    logic [15:0] current_cost;
    logic [15:0] nb_cost;
    logic [15:0] sel_index;

    logic [15:0] nb_addr, nb_addr4;
    logic        nb_rd_en, nb_rd_en4;
    logic [15:0] cnt, cnt4;
    logic        ovf, ovf4;
    logic        done, done4;
    logic [15:0] sel_nb, sel_nb4;

    logic [15:0] mem [8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    better_neighbor_scan #(.NUM_NEIGHBORS(8), .MAX_BETTER(16), .COST_W(16)) dut (
        .clock(clock), .nreset(nreset), .start_scan(start_scan), .current_cost(current_cost),
        .nb_addr(nb_addr), .nb_rd_en(nb_rd_en), .nb_cost(nb_cost),
        .betterNeighborCount(cnt), .overflow(ovf), .done_scan(done),
        .sel_index(sel_index), .sel_neighbor(sel_nb)
    );

    better_neighbor_scan #(.NUM_NEIGHBORS(8), .MAX_BETTER(4), .COST_W(16)) dut4 (
        .clock(clock), .nreset(nreset), .start_scan(start_scan), .current_cost(current_cost),
        .nb_addr(nb_addr4), .nb_rd_en(nb_rd_en4), .nb_cost(nb_cost),
        .betterNeighborCount(cnt4), .overflow(ovf4), .done_scan(done4),
        .sel_index(sel_index), .sel_neighbor(sel_nb4)
    );

    // Synchronous-read cost memory: data appears one cycle after the read
    always @(posedge clock) begin
        if (nb_rd_en) nb_cost <= mem[nb_addr[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done_scan after the accepting edge; optionally perturbs current_cost
    task automatic wait_done(input string tag, input bit chg, input logic [15:0] alt);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            if (chg && cyc == 3) current_cost = alt;
        end while (!done && cyc < 30);
        check({tag, "_latency"}, 32'(cyc), 32'd10);
        check({tag, "_done4"}, 32'(done4), 32'd1);
    endtask

    task automatic run_scan(input string tag, input logic [15:0] cost, input bit chg,
                            input logic [15:0] alt);
        @(negedge clock);
        start_scan = 1'b0;
        @(negedge clock);
        current_cost = cost;
        start_scan   = 1'b1;
        @(posedge clock);
        wait_done(tag, chg, alt);
    endtask

    task automatic check_sel(input string tag, input logic [15:0] idx,
                             input logic [15:0] exp_main, input logic [15:0] exp4);
        @(negedge clock);
        sel_index = idx;
        #1;
        check({tag, "_sel"}, 32'(sel_nb), 32'(exp_main));
        check({tag, "_sel4"}, 32'(sel_nb4), 32'(exp4));
    endtask

    initial begin
        int bad;
        nreset       = 1'b0;
        start_scan   = 1'b0;
        current_cost = 16'd0;
        sel_index    = 16'd0;
        mem = '{16'd60, 16'd40, 16'd50, 16'd10, 16'd70, 16'd49, 16'd51, 16'd0};
        repeat (2) @(posedge clock);
        #1;
        check("rst_rd_en", 32'(nb_rd_en), 32'd0);
        check("rst_addr", 32'(nb_addr), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        nreset = 1'b1;

        // Mixed costs around 50: better at 1,3,5,7; exactly fills the 4-deep list
        run_scan("mixed", 16'd50, 1'b0, 16'd0);
        check("mixed_count", 32'(cnt), 32'd4);
        check("mixed_ovf", 32'(ovf), 32'd0);
        check("mixed_count4", 32'(cnt4), 32'd4);
        check("mixed_ovf4", 32'(ovf4), 32'd0);
        check_sel("mixed0", 16'd0, 16'd1, 16'd1);
        check_sel("mixed1", 16'd1, 16'd3, 16'd3);
        check_sel("mixed2", 16'd2, 16'd5, 16'd5);
        check_sel("mixed3", 16'd3, 16'd7, 16'd7);
        check_sel("mixed4", 16'd4, 16'd0, 16'd0);

        // All below current cost: 4-deep instance saturates and flags overflow
        mem = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        run_scan("all", 16'd100, 1'b0, 16'd0);
        check("all_count", 32'(cnt), 32'd8);
        check("all_ovf", 32'(ovf), 32'd0);
        check("all_count4", 32'(cnt4), 32'd4);
        check("all_ovf4", 32'(ovf4), 32'd1);
        check_sel("all0", 16'd0, 16'd0, 16'd0);
        check_sel("all3", 16'd3, 16'd3, 16'd3);
        check_sel("all7", 16'd7, 16'd7, 16'd0);
        check_sel("all8", 16'd8, 16'd0, 16'd0);

        // start_scan held high in DONE must not retrigger
        bad = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (nb_rd_en !== 1'b0 || done !== 1'b1) bad++;
        end
        check("hold_no_rescan", 32'(bad), 32'd0);

        // Drop start for one cycle, then rescan at cost 20: better at 3 and 7 only
        @(negedge clock);
        start_scan = 1'b0;
        @(posedge clock);
        #1;
        check("drop_done", 32'(done), 32'd0);
        check("drop_count_kept", 32'(cnt), 32'd8);
        mem = '{16'd60, 16'd40, 16'd50, 16'd10, 16'd70, 16'd49, 16'd51, 16'd0};
        @(negedge clock);
        current_cost = 16'd20;
        start_scan   = 1'b1;
        @(posedge clock);
        wait_done("rescan", 1'b0, 16'd0);
        check("rescan_count", 32'(cnt), 32'd2);
        check("rescan_count4", 32'(cnt4), 32'd2);
        check("rescan_ovf4", 32'(ovf4), 32'd0);
        check_sel("rescan0", 16'd0, 16'd3, 16'd3);
        check_sel("rescan1", 16'd1, 16'd7, 16'd7);

        // All equal to current cost: nothing is better, stale list entries stay hidden
        mem = '{16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
        run_scan("equal", 16'd50, 1'b0, 16'd0);
        check("equal_count", 32'(cnt), 32'd0);
        check("equal_done", 32'(done), 32'd1);
        check_sel("equal0", 16'd0, 16'd0, 16'd0);
        check_sel("equal1", 16'd1, 16'd0, 16'd0);

        // Reset mid-scan aborts; start still high begins a fresh scan afterwards
        mem = '{16'd60, 16'd40, 16'd50, 16'd10, 16'd70, 16'd49, 16'd51, 16'd0};
        @(negedge clock);
        start_scan = 1'b0;
        @(negedge clock);
        current_cost = 16'd50;
        start_scan   = 1'b1;
        @(posedge clock);
        repeat (4) @(posedge clock);
        @(negedge clock);
        nreset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_count", 32'(cnt), 32'd0);
        check("midrst_rd_en", 32'(nb_rd_en), 32'd0);
        check("midrst_addr", 32'(nb_addr), 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        @(posedge clock);
        wait_done("midrst_rescan", 1'b0, 16'd0);
        check("midrst_rescan_count", 32'(cnt), 32'd4);
        check_sel("midrst2", 16'd2, 16'd5, 16'd5);

        // current_cost changed to 5 mid-scan: latched 50 must still be used
        run_scan("latch", 16'd50, 1'b1, 16'd5);
        check("latch_count", 32'(cnt), 32'd4);
        check_sel("latch0", 16'd0, 16'd1, 16'd1);
        check_sel("latch2", 16'd2, 16'd5, 16'd5);
        check_sel("latch3", 16'd3, 16'd7, 16'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
